// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  // Data-cache miss sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    RESUME = 2'd2,
    ERROR  = 2'd3
  } miss_state_t;

  // Execute-stage result source that marks a load
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/miss_fsm.sv
// rtl/miss_fsm.sv - data-cache miss sequencer with refill handshake and timeout
module miss_fsm
  import hazard_pkg::*;
#(
  parameter int MISS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_m_i,
  input  logic        mem_ready_i,
  output miss_state_t state_o,
  output logic        refill_req_o,
  output logic        bus_error_o
);

  localparam int CW = $clog2(MISS_TIMEOUT + 1);
  // Count value seen during the last permitted MISS cycle
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(MISS_TIMEOUT - 1);

  miss_state_t   state_q;
  miss_state_t   state_d;
  logic [CW-1:0] timeout_cnt;
  logic          timeout_hit;

  // Timeout fires on the MISS_TIMEOUT-th consecutive MISS cycle
  assign timeout_hit = (state_q == MISS) && (timeout_cnt == TIMEOUT_LAST);
  assign state_o     = state_q;

  // Next-state decode; a refill completion beats a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_m_i) state_d = MISS;
      MISS: begin
        if (mem_ready_i)      state_d = RESUME;
        else if (timeout_hit) state_d = ERROR;
      end
      RESUME:  state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Timeout counter: held at zero outside MISS, so every MISS entry starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  timeout_cnt <= '0;
    else if (state_q != MISS) timeout_cnt <= '0;
    else                      timeout_cnt <= timeout_cnt + 1'b1;
  end

  // Registered handshake/error outputs track the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill_req_o <= 1'b0;
      bus_error_o  <= 1'b0;
    end else begin
      refill_req_o <= (state_d == MISS);
      bus_error_o  <= bus_error_o | (state_d == ERROR);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush controller for the five-stage pipeline
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_d_i,
  input  logic [ADDR_WIDTH-1:0] rs2_d_i,
  input  logic [ADDR_WIDTH-1:0] rd_e_i,
  input  logic                  reg_write_e_i,
  input  logic [1:0]            result_src_e_i,
  input  logic                  pc_src_e_i,
  input  logic                  miss_m_i,
  input  logic                  mem_ready_i,
  output logic                  en_f_o,
  output logic                  en_d_o,
  output logic                  en_e_o,
  output logic                  en_m_o,
  output logic                  en_w_o,
  output logic                  clear_d_o,
  output logic                  clear_e_o,
  output logic                  refill_req_o,
  output logic                  bus_error_o,
  output logic [DATA_WIDTH-1:0] stall_count_o
);

  miss_state_t state;
  logic        freeze;
  logic        load_use;

  miss_fsm #(
    .MISS_TIMEOUT(MISS_TIMEOUT)
  ) u_miss_fsm (
    .clk          (clk),
    .rst          (rst),
    .miss_m_i     (miss_m_i),
    .mem_ready_i  (mem_ready_i),
    .state_o      (state),
    .refill_req_o (refill_req_o),
    .bus_error_o  (bus_error_o)
  );

  // Freeze starts combinationally in the cycle the miss is first seen
  assign freeze = ((state == IDLE) && miss_m_i) || (state != IDLE);

  assign load_use = (result_src_e_i == RESULT_SRC_LOAD) && reg_write_e_i &&
                    (rd_e_i != '0) && ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // Output priority: freeze, then taken branch, then load-use bubble
  always_comb begin
    en_f_o    = 1'b1;
    en_d_o    = 1'b1;
    en_e_o    = 1'b1;
    en_m_o    = 1'b1;
    en_w_o    = 1'b1;
    clear_d_o = 1'b0;
    clear_e_o = 1'b0;
    if (freeze) begin
      en_f_o = 1'b0;
      en_d_o = 1'b0;
      en_e_o = 1'b0;
      en_m_o = 1'b0;
      en_w_o = 1'b0;
    end else if (pc_src_e_i) begin
      clear_d_o = 1'b1;
      clear_e_o = 1'b1;
    end else if (load_use) begin
      en_f_o    = 1'b0;
      en_d_o    = 1'b0;
      clear_e_o = 1'b1;
    end
  end

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count_o <= '0;
    else if (!en_f_o && (stall_count_o != '1))
      stall_count_o <= stall_count_o + 1'b1;
  end

endmodule
